// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: FSM encoding and
// the chunk-index width helper.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a counter covering 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
// Purely combinational; no state and no flow control.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// W-bit combinational ripple-carry slice built from fa cells.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock; done pulses N edges
// after start. No backpressure: start is ignored while RUN, accepted in IDLE/DONE.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] s_ext;
  logic [WIDTH-1:0] sum_nxt;

  // Operands shift right each RUN cycle, so the active chunk is always the low slice.
  rca_chunk #(.W(CHUNK)) u_rca (
    .a     (a_r[CHUNK-1:0]),
    .b     (b_r[CHUNK-1:0]),
    .ci    (carry),
    .s     (s_chunk),
    .co    (c_out),
    .c_msb (c_msb)
  );

  always_comb begin
    s_ext              = '0;
    s_ext[CHUNK-1:0]   = s_chunk;
    sum_nxt            = sum | (s_ext << (idx * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          sum   <= sum_nxt;
          carry <= c_out;
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_out;
            ovf   <= c_out ^ c_msb;
            zero  <= (sum_nxt == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= cin ^ sub;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Randomised and directed bench for seq_addsub (WIDTH=16, CHUNK=4) against an
// arithmetic reference model.
module tb_seq_addsub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout, ovf, zero;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  // Flags the DUT should still be showing from the previous completed op.
  logic last_c = 1'b0, last_o = 1'b0, last_z = 1'b0;

  seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on a WIDTH+1 bit result; overflow from operand signs.
  function automatic logic [WIDTH+2:0] ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                              input logic rsub, input logic rcin);
    logic [WIDTH-1:0] beff;
    logic [WIDTH:0]   full;
    logic             o;
    beff = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, beff} + {{WIDTH{1'b0}}, rcin ^ rsub};
    o    = (ra[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
    return {o, (full[WIDTH-1:0] == '0), full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Issue start for one edge, then scramble inputs to show they are not re-sampled.
  task automatic launch(input logic [WIDTH-1:0] la, input logic [WIDTH-1:0] lb,
                        input logic lsub, input logic lcin);
    @(negedge clk);
    a = la; b = lb; sub = lsub; cin = lcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    check("launch_busy", busy, 1);
    check("launch_done", done, 0);
    check("launch_sum_clr", sum, 0);
    check("launch_flags_hold", {cout, ovf, zero}, {last_c, last_o, last_z});
  endtask

  // Waits out the RUN edges; optionally pulses a stray start during RUN.
  task automatic finish_op(input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                           input logic ez, input bit poke);
    for (int k = 1; k < N; k++) begin
      if (poke && k == 1) begin
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("run_busy", busy, 1);
      check("run_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    check("zero", zero, ez);
    last_c = ec; last_o = eo; last_z = ez;
  endtask

  task automatic idle_after(input logic [WIDTH-1:0] es);
    @(posedge clk);
    #1;
    check("post_done_low", done, 0);
    check("post_busy_low", busy, 0);
    check("post_sum_hold", sum, es);
    check("post_flags_hold", {cout, ovf, zero}, {last_c, last_o, last_z});
  endtask

  task automatic rand_op();
    logic [WIDTH-1:0] ra, rb;
    logic rs, rc;
    logic [WIDTH+2:0] r;
    ra = WIDTH'($urandom);
    rb = WIDTH'($urandom);
    case ($urandom_range(3, 0))
      0: ra = 16'h7FFF;
      1: rb = ra;
      default: ;
    endcase
    rs = 1'($urandom);
    rc = 1'($urandom);
    r  = ref_op(ra, rb, rs, rc);
    launch(ra, rb, rs, rc);
    finish_op(r[WIDTH-1:0], r[WIDTH], r[WIDTH+2], r[WIDTH+1], 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    #1;
    check("rst_state", {busy, done, cout, ovf, zero}, 5'b0);
    check("rst_sum", sum, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain add, carry across chunk boundary
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    finish_op(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_after(16'h0100);

    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    finish_op(16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_after(16'h8000);
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    finish_op(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_after(16'h0000);

    launch(16'h0005, 16'h0007, 1'b1, 1'b0);
    finish_op(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_after(16'hFFFE);
    launch(16'h8000, 16'h0001, 1'b1, 1'b0);
    finish_op(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_after(16'h7FFF);
    launch(16'h0005, 16'h0002, 1'b1, 1'b1);
    finish_op(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_after(16'h0002);

    // Stray start during RUN must not disturb the op
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    finish_op(16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_after(16'h2345);

    // Back-to-back: start accepted in the DONE cycle
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    finish_op(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(16'h0001, 16'h0001, 1'b0, 1'b0);
    finish_op(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN aborts without a done pulse
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {busy, done, cout, ovf, zero}, 5'b0);
    check("arst_sum", sum, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_c = 1'b0; last_o = 1'b0; last_z = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("arst_no_done", pulses, 0);
    launch(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    finish_op(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_after(16'h0000);

    // Random ops, randomly back-to-back or with an idle gap
    for (int i = 0; i < 60; i++) begin
      rand_op();
      if ($urandom_range(1, 0) == 1) idle_after(sum);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
